// File: rtl/cp0_regfile_v2.sv
// Coprocessor-0 register file: BadVAddr/Count/Compare/Status/Cause/EPC/EBase, timer, interrupts, exception vector.
// Optional Compare/TI timer is enabled by defining CP0_TIMER_EN; reads return the same-cycle next-state view.
module cp0_regfile_v2 #(
  parameter int          NUM_HW_INT      = 6,
  parameter int          INT_SYNC_STAGES = 2,
  parameter int          COUNT_DIV       = 2,
  parameter logic [31:0] RESET_EBASE     = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  input  logic [2:0]            rsel1,
  input  logic [2:0]            rsel2,
  output logic [31:0]           rdata1,
  output logic [31:0]           rdata2,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [2:0]            wsel,
  input  logic [31:0]           wdata,
  input  logic                  exc_flush,
  input  logic                  exc_eret,
  input  logic                  exc_delayslot,
  input  logic [31:0]           exc_pc,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_badvaddr,
  input  logic [1:0]            exc_ce,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_pending,
  output logic [31:0]           exc_vector,
  output logic [31:0]           status_q,
  output logic [31:0]           cause_q,
  output logic [31:0]           epc_q
);

  localparam int          PW          = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [31:0] STATUS_MASK = 32'h1040_FF07;
  localparam logic [31:0] CAUSE_MASK  = 32'h0000_0300;
  localparam logic [31:0] EBASE_MASK  = 32'h3FFF_F000;
  localparam logic [31:0] STATUS_RST  = 32'h1040_0000;

  logic [31:0]   badvaddr_q, count_q, ebase_q;
  logic [PW-1:0] presc_q, presc_n;
  logic [31:0]   badvaddr_n, count_n, ebase_n, status_n, cause_n, epc_n, compare_n;
  logic          ti_n, inc;
  logic [5:0]    ip_hw;
  logic [NUM_HW_INT-1:0] hw_s;

`ifdef CP0_TIMER_EN
  logic [31:0] compare_q;
  logic        ti_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      compare_q <= compare_n;
      ti_q      <= ti_n;
    end
  end
`endif

  generate
    if (INT_SYNC_STAGES == 0) begin : g_nosync
      assign hw_s = hw_int;
    end else begin : g_sync
      logic [NUM_HW_INT-1:0] stage_q [INT_SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < INT_SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= hw_int;
          for (int i = 1; i < INT_SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign hw_s = stage_q[INT_SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    inc     = (presc_q == PRESC_MAX);
    presc_n = inc ? '0 : presc_q + PW'(1);
    count_n = count_q + {31'b0, inc};
`ifdef CP0_TIMER_EN
    compare_n = compare_q;
    ti_n      = ti_q | (inc && (count_n == compare_q));
`else
    compare_n = '0;
    ti_n      = 1'b0;
`endif
    status_n   = status_q;
    cause_n    = cause_q;
    epc_n      = epc_q;
    badvaddr_n = badvaddr_q;
    ebase_n    = ebase_q;

    if (we && wsel == 3'd0) begin
      case (waddr)
        5'd9: begin
          count_n = wdata;
          presc_n = '0;
        end
`ifdef CP0_TIMER_EN
        5'd11: begin
          compare_n = wdata;
          ti_n      = 1'b0;
        end
`endif
        5'd12:   status_n = (status_q & ~STATUS_MASK) | (wdata & STATUS_MASK);
        5'd13:   cause_n  = (cause_q & ~CAUSE_MASK) | (wdata & CAUSE_MASK);
        5'd14:   epc_n    = wdata;
        default: ;
      endcase
    end
    if (we && waddr == 5'd15 && wsel == 3'd1)
      ebase_n = (ebase_q & ~EBASE_MASK) | (wdata & EBASE_MASK);

    // Hardware IP bits and TI are rebuilt every cycle from the live sources.
    ip_hw                   = '0;
    ip_hw[NUM_HW_INT-1:0]   = hw_s;
    ip_hw[5]                = ip_hw[5] | ti_n;
    cause_n[15:10]          = ip_hw;
    cause_n[30]             = ti_n;

    if (exc_flush && !exc_eret) begin
      if (!status_q[1]) begin
        cause_n[31] = exc_delayslot;
        epc_n       = exc_delayslot ? exc_pc - 32'd4 : exc_pc;
      end
      status_n[1]    = 1'b1;
      cause_n[6:2]   = exc_code;
      cause_n[29:28] = exc_ce;
      if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_n = exc_badvaddr;
    end else if (exc_flush && exc_eret) begin
      if (status_n[2]) status_n[2] = 1'b0;
      else             status_n[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ebase_q    <= RESET_EBASE;
    end else begin
      presc_q    <= presc_n;
      count_q    <= count_n;
      status_q   <= status_n;
      cause_q    <= cause_n;
      epc_q      <= epc_n;
      badvaddr_q <= badvaddr_n;
      ebase_q    <= ebase_n;
    end
  end

  function automatic logic [31:0] rd_mux(input logic [4:0] a, input logic [2:0] s,
                                         input logic [31:0] bv, input logic [31:0] cnt,
                                         input logic [31:0] cmp, input logic [31:0] st,
                                         input logic [31:0] ca, input logic [31:0] ep,
                                         input logic [31:0] eb);
    logic [31:0] r;
    r = '0;
    if (s == 3'd0) begin
      case (a)
        5'd8:    r = bv;
        5'd9:    r = cnt;
        5'd11:   r = cmp;
        5'd12:   r = st;
        5'd13:   r = ca;
        5'd14:   r = ep;
        default: r = '0;
      endcase
    end else if (s == 3'd1 && a == 5'd15) begin
      r = eb;
    end
    return r;
  endfunction

  always_comb begin
    rdata1 = rd_mux(raddr1, rsel1, badvaddr_n, count_n, compare_n, status_n, cause_n, epc_n, ebase_n);
    rdata2 = rd_mux(raddr2, rsel2, badvaddr_n, count_n, compare_n, status_n, cause_n, epc_n, ebase_n);
  end

  assign int_pending = status_q[0] & ~status_q[1] & ~status_q[2] & |(cause_q[15:8] & status_q[15:8]);
  assign exc_vector  = exc_eret    ? epc_q :
                       status_q[22] ? 32'hBFC0_0380 : {ebase_q[31:12], 12'h180};

endmodule
